// File: rtl/dmem_responder.sv
`default_nettype none
// =============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with programmable wait states, store
//            byte-lane merging, right-aligned sub-word loads and error flags.
// Revision : 1.0 - initial release
// =============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    input  logic [31:0] input_ddata,
    output logic [31:0] output_ddata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        derr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         C_DEPTH     = 2 ** ADDR_WIDTH;
    localparam int         C_AW        = ADDR_WIDTH + 2;
    localparam logic [3:0] C_WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [C_AW-1:0]   addr_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              dready_n_q;
    logic              derr_q;

    logic [31:0]       mem [C_DEPTH];

    logic              w_in_err;
    logic [C_AW-1:0]   w_addr;
    logic [31:0]       w_wdat;
    logic              w_wr;
    logic [1:0]        w_size;
    logic              w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_enter_resp;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_word;
    logic [31:0]       w_shift;
    logic [31:0]       w_rdata;

    always_comb begin
        w_in_err = 1'b0;
        case (dsize)
            2'b00:   w_in_err = 1'b0;
            2'b01:   w_in_err = daddr[0];
            2'b10:   w_in_err = |daddr[1:0];
            default: w_in_err = 1'b1;
        endcase
        if ((daddr >> C_AW) != 32'd0) begin
            w_in_err = 1'b1;
        end
    end

    // With LATENCY=0 the commit happens on the capture edge, so the live
    // inputs must be used while still in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            w_addr = daddr[C_AW-1:0];
            w_wdat = input_ddata;
            w_wr   = dwrite;
            w_size = dsize;
            w_err  = w_in_err;
        end else begin
            w_addr = addr_q;
            w_wdat = wdata_q;
            w_wr   = write_q;
            w_size = size_q;
            w_err  = err_q;
        end
    end

    assign w_idx        = w_addr[C_AW-1:2];
    assign w_lane       = w_addr[1:0];
    assign w_enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        w_be = 4'b0000;
        w_wd = 32'd0;
        case (w_size)
            2'b00: begin
                w_be[w_lane] = 1'b1;
                w_wd         = {4{w_wdat[7:0]}};
            end
            2'b01: begin
                w_be = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_wdat[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = w_wdat;
            end
        endcase
    end

    always_comb begin
        w_word  = mem[w_idx];
        w_shift = w_word >> {w_lane, 3'b000};
        case (w_size)
            2'b00:   w_rdata = {24'd0, w_shift[7:0]};
            2'b01:   w_rdata = {16'd0, w_shift[15:0]};
            default: w_rdata = w_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dbusy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dreq) begin
                    dbusy = 1'b1;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                dbusy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            dready_n_q <= 1'b1;
            derr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && dreq) begin
                addr_q  <= daddr[C_AW-1:0];
                wdata_q <= input_ddata;
                write_q <= dwrite;
                size_q  <= dsize;
                err_q   <= w_in_err;
            end
            if (w_enter_resp) begin
                rdata_q <= (w_wr || w_err) ? 32'd0 : w_rdata;
            end
            dready_n_q <= (state_d != S_RESP);
            derr_q     <= (state_d == S_RESP) && w_err;
        end
    end

    // Array is deliberately not reset; rst gates a LATENCY=0 commit.
    always_ff @(posedge clk) begin
        if (rst && w_enter_resp && w_wr && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    assign output_ddata = rdata_q;
    assign dready_n     = dready_n_q;
    assign derr         = derr_q;

endmodule
`default_nettype wire
